// File: rtl/tl_responder_pkg.sv
// tl_responder_pkg: TileLink opcodes, FSM states and request record shared by the responder slice
package tl_responder_pkg;
  localparam int SRC_W = 4;
  localparam logic [2:0] TL_PUT_FULL = 3'd0;
  localparam logic [2:0] TL_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] TL_GET = 3'd4;
  localparam logic [2:0] TL_ACCESS_ACK = 3'd0;
  localparam logic [2:0] TL_ACCESS_ACK_DATA = 3'd1;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;
  typedef struct packed {
    logic [2:0] opcode;
    logic [2:0] size;
    logic [SRC_W-1:0] source;
    logic [63:0] address;
    logic [7:0] mask;
    logic [63:0] data;
  } req_t;
  function automatic logic is_put(input logic [2:0] op);
    return op == TL_PUT_FULL || op == TL_PUT_PARTIAL;
  endfunction
endpackage

// File: rtl/tl_responder_if.sv
// tilelink: A channel (master->slave request) and D channel (slave->master response), master/slave modports
interface tilelink;
  logic a_valid;
  logic a_ready;
  logic [2:0] a_opcode;
  logic [2:0] a_size;
  logic [tl_responder_pkg::SRC_W-1:0] a_source;
  logic [63:0] a_address;
  logic [7:0] a_mask;
  logic [63:0] a_data;
  logic d_valid;
  logic d_ready;
  logic [2:0] d_opcode;
  logic [1:0] d_param;
  logic [2:0] d_size;
  logic [tl_responder_pkg::SRC_W-1:0] d_source;
  logic d_error;
  logic [63:0] d_data;
  modport master (
    output a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data, d_ready,
    input a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_error, d_data
  );
  modport slave (
    input a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data, d_ready,
    output a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_error, d_data
  );
endinterface

// File: rtl/tl_ram.sv
// tl_ram: DEPTH x 64-bit byte-masked store; clk, we/addr/mask/wdata sync write, rdata async read, never reset
module tl_ram #(
  parameter int DEPTH = 512,
  localparam int AW = $clog2(DEPTH)
) (
  input logic clk,
  input logic we,
  input logic [AW-1:0] addr,
  input logic [7:0] mask,
  input logic [63:0] wdata,
  output logic [63:0] rdata
);
  logic [63:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we)
      for (int i = 0; i < 8; i++)
        if (mask[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
  assign rdata = mem[addr];
endmodule

// File: rtl/tl_responder.sv
// tl_responder: TileLink-UL memory slave; clk/rst, bus (A sink, D source), busy, ack_cnt (completed D handshakes)
module tl_responder
  import tl_responder_pkg::*;
#(
  parameter int DEPTH = 512,
  parameter logic [63:0] BASE = 64'h0000_0000_8000_0000,
  parameter int LATENCY = 2,
  parameter logic UNCACHED = 1'b0
) (
  input logic clk,
  input logic rst,
  tilelink.slave bus,
  output logic busy,
  output logic [31:0] ack_cnt
);
  localparam int AW = $clog2(DEPTH);
  state_e state, next;
  req_t req;
  logic [3:0] cnt;
  logic fresh, acc, hs, is_get, err, we, rd_ok;
  logic [63:0] off, rdata;
  assign acc = bus.a_valid && bus.a_ready;
  assign hs = bus.d_valid && bus.d_ready;
  assign off = req.address - BASE;
  assign is_get = req.opcode == TL_GET;
  assign err = !(is_get || is_put(req.opcode)) || req.size > 3'd3 ||
               (req.address[2:0] & 3'((4'd1 << req.size[1:0]) - 4'd1)) != 3'd0 ||
               req.address < BASE || off >= (64'(DEPTH) << 3);
  assign we = fresh && state == ST_RESP && !rst && is_put(req.opcode) && !err;
  assign rd_ok = state == ST_RESP && !rst && is_get && !err;
  always_ff @(posedge clk) state <= rst ? ST_IDLE : next;
  always_comb
    next = state == ST_IDLE ? (acc ? (LATENCY == 0 ? ST_RESP : ST_WAIT) : ST_IDLE) :
           state == ST_WAIT ? (cnt == 4'd0 ? ST_RESP : ST_WAIT) :
           (hs ? ST_IDLE : ST_RESP);
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 4'd0;
      fresh <= 1'b0;
      ack_cnt <= 32'd0;
    end else begin
      if (acc) req <= {bus.a_opcode, bus.a_size, bus.a_source, bus.a_address, bus.a_mask, bus.a_data};
      cnt <= state != ST_WAIT && next == ST_WAIT ? 4'(LATENCY - 1) :
             cnt - {3'd0, state == ST_WAIT && cnt != 4'd0};
      fresh <= state != ST_RESP && next == ST_RESP;
      if (hs) ack_cnt <= ack_cnt + 32'd1;
    end
  end
  always_comb begin
    bus.a_ready = state == ST_IDLE && !rst;
    bus.d_valid = state == ST_RESP && !rst;
    bus.d_opcode = rd_ok ? TL_ACCESS_ACK_DATA : TL_ACCESS_ACK;
    bus.d_data = rd_ok ? rdata : 64'd0;
    bus.d_error = state == ST_RESP && !rst && err;
    bus.d_param = {1'b0, UNCACHED};
    bus.d_size = req.size;
    bus.d_source = req.source;
    busy = state != ST_IDLE && !rst;
  end
  tl_ram #(.DEPTH(DEPTH)) u_ram (
    .clk(clk),
    .we(we),
    .addr(off[AW+2:3]),
    .mask(req.mask),
    .wdata(req.data),
    .rdata(rdata)
  );
endmodule

// File: tb/tb_tl_responder.sv
// tb_tl_responder: directed scoreboard bench for tl_responder (LATENCY=2 instance and LATENCY=0/UNCACHED instance)
module tb_tl_responder;
  localparam logic [63:0] B = 64'h0000_0000_8000_0000;
  logic clk = 1'b0;
  logic rst0, rst1, busy0, busy1;
  logic [31:0] ack0, ack1;
  int checks = 0, errors = 0, done0 = 0, cyc = 0;
  logic [76:0] q0[$], q1[$];
  logic [2:0] v_op[5] = '{3'd0, 3'd4, 3'd1, 3'd4, 3'd4};
  logic [63:0] v_addr[5] = '{B + 64'h8, B + 64'h8, B + 64'h8, B + 64'h8, B + 64'h80};
  logic [7:0] v_mask[5] = '{8'hFF, 8'hFF, 8'hF0, 8'hFF, 8'hFF};
  logic [63:0] v_data[5] = '{64'h0123456789ABCDEF, 64'd0, 64'hFFFFFFFF_00000000, 64'd0, 64'd0};
  logic [2:0] e_op[5] = '{3'd0, 3'd1, 3'd0, 3'd1, 3'd0};
  logic e_err[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [63:0] e_data[5] = '{64'd0, 64'h0123456789ABCDEF, 64'd0, 64'hFFFFFFFF_89ABCDEF, 64'd0};
  tilelink b0();
  tilelink b1();
  tl_responder dut0 (.clk(clk), .rst(rst0), .bus(b0), .busy(busy0), .ack_cnt(ack0));
  tl_responder #(.DEPTH(16), .LATENCY(0), .UNCACHED(1'b1)) dut1 (
    .clk(clk), .rst(rst1), .bus(b1), .busy(busy1), .ack_cnt(ack1)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, exp);
    end
  endtask
  always @(negedge clk)
    if (b0.d_valid && b0.d_ready) begin
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL d0_unexpected got data %0h want no response", b0.d_data);
      end else begin
        chk("d0_resp", 128'({b0.d_opcode, b0.d_param, b0.d_size, b0.d_source, b0.d_error, b0.d_data}),
            128'(q0.pop_front()));
        done0++;
      end
    end
  always @(negedge clk)
    if (b1.d_valid && b1.d_ready) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL d1_unexpected got data %0h want no response", b1.d_data);
      end else
        chk("d1_resp", 128'({b1.d_opcode, b1.d_param, b1.d_size, b1.d_source, b1.d_error, b1.d_data}),
            128'(q1.pop_front()));
    end
  task automatic issue0(input logic [2:0] op, input logic [2:0] sz, input logic [3:0] src,
                        input logic [63:0] addr, input logic [7:0] mask, input logic [63:0] data,
                        input logic [2:0] eop, input logic eerr, input logic [63:0] edata);
    int n;
    b0.a_valid = 1'b1;
    b0.a_opcode = op;
    b0.a_size = sz;
    b0.a_source = src;
    b0.a_address = addr;
    b0.a_mask = mask;
    b0.a_data = data;
    n = 0;
    @(negedge clk);
    while (!b0.a_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("d0_accept", 128'(b0.a_ready), 128'd1);
    q0.push_back({eop, 2'b00, sz, src, eerr, edata});
    @(posedge clk);
    #1 b0.a_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!b0.d_valid && n < 40);
    chk("d0_latency", 128'(n), 128'd3);
    if (b0.d_ready) begin
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    int n, prev;
    rst0 = 1'b1;
    rst1 = 1'b1;
    {b0.a_valid, b0.a_opcode, b0.a_size, b0.a_source, b0.a_address, b0.a_mask, b0.a_data} = '0;
    {b1.a_valid, b1.a_opcode, b1.a_size, b1.a_source, b1.a_address, b1.a_mask, b1.a_data} = '0;
    b0.d_ready = 1'b1;
    b1.d_ready = 1'b1;
    prev = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_a_ready", 128'(b0.a_ready), 128'd0);
    chk("rst_d_valid", 128'(b0.d_valid), 128'd0);
    chk("rst_busy", 128'(busy0), 128'd0);
    chk("rst_ack_cnt", 128'(ack0), 128'd0);
    chk("rst_d_fields", 128'({b0.d_error, b0.d_opcode, b0.d_data}), 128'd0);
    chk("rst1_a_ready", 128'(b1.a_ready), 128'd0);
    @(posedge clk);
    #1 rst0 = 1'b0;
    rst1 = 1'b0;
    @(negedge clk);
    chk("idle_a_ready", 128'(b0.a_ready), 128'd1);
    @(posedge clk);
    #1;
    issue0(3'd0, 3'd3, 4'd1, B + 64'h10, 8'hFF, 64'h1122334455667788, 3'd0, 1'b0, 64'd0);
    issue0(3'd4, 3'd3, 4'd2, B + 64'h10, 8'hFF, 64'd0, 3'd1, 1'b0, 64'h1122334455667788);
    issue0(3'd1, 3'd3, 4'd3, B + 64'h10, 8'h0F, 64'hAAAAAAAA_BBBBBBBB, 3'd0, 1'b0, 64'd0);
    issue0(3'd4, 3'd3, 4'd4, B + 64'h10, 8'hFF, 64'd0, 3'd1, 1'b0, 64'h11223344_BBBBBBBB);
    issue0(3'd0, 3'd3, 4'd5, B, 8'hFF, 64'h5555666677778888, 3'd0, 1'b0, 64'd0);
    issue0(3'd4, 3'd3, 4'd6, B + 64'h1000, 8'hFF, 64'd0, 3'd0, 1'b1, 64'd0);
    issue0(3'd4, 3'd3, 4'd7, B + 64'h4, 8'hFF, 64'd0, 3'd0, 1'b1, 64'd0);
    issue0(3'd0, 3'd3, 4'd8, B + 64'h1000, 8'hFF, '1, 3'd0, 1'b1, 64'd0);
    issue0(3'd0, 3'd3, 4'd9, B + 64'h4, 8'hFF, '1, 3'd0, 1'b1, 64'd0);
    issue0(3'd2, 3'd3, 4'd10, B, 8'hFF, '1, 3'd0, 1'b1, 64'd0);
    issue0(3'd4, 3'd4, 4'd11, B, 8'hFF, 64'd0, 3'd0, 1'b1, 64'd0);
    issue0(3'd0, 3'd3, 4'd12, B - 64'h8, 8'hFF, '1, 3'd0, 1'b1, 64'd0);
    issue0(3'd4, 3'd3, 4'd13, B, 8'hFF, 64'd0, 3'd1, 1'b0, 64'h5555666677778888);
    issue0(3'd4, 3'd2, 4'd14, B + 64'h14, 8'hFF, 64'd0, 3'd1, 1'b0, 64'h11223344_BBBBBBBB);
    issue0(3'd4, 3'd1, 4'd15, B + 64'h11, 8'hFF, 64'd0, 3'd0, 1'b1, 64'd0);
    chk("ack_cnt_15", 128'(ack0), 128'd15);
    b0.d_ready = 1'b0;
    issue0(3'd4, 3'd3, 4'd0, B + 64'h10, 8'hFF, 64'd0, 3'd1, 1'b0, 64'h11223344_BBBBBBBB);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_d_valid", 128'(b0.d_valid), 128'd1);
      chk("stall_d_data", 128'(b0.d_data), 128'h11223344_BBBBBBBB);
      chk("stall_a_ready", 128'(b0.a_ready), 128'd0);
    end
    chk("stall_ack_hold", 128'(ack0), 128'd15);
    @(posedge clk);
    #1 b0.d_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("stall_ack_inc", 128'(ack0), 128'd16);
    chk("stall_released", 128'(b0.d_valid), 128'd0);
    @(posedge clk);
    #1;
    chk("stall_ack_once", 128'(ack0), 128'd16);
    b0.a_valid = 1'b1;
    b0.a_opcode = 3'd0;
    b0.a_size = 3'd3;
    b0.a_source = 4'd1;
    b0.a_address = B + 64'h10;
    b0.a_mask = 8'hFF;
    b0.a_data = 64'h9999999999999999;
    n = 0;
    @(negedge clk);
    while (!b0.a_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("rput_accept", 128'(b0.a_ready), 128'd1);
    @(posedge clk);
    #1 b0.a_valid = 1'b0;
    @(negedge clk);
    chk("rput_busy", 128'(busy0), 128'd1);
    chk("rput_wait_d_valid", 128'(b0.d_valid), 128'd0);
    rst0 = 1'b1;
    @(posedge clk);
    #1 rst0 = 1'b0;
    done0 = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rput_dropped", 128'(b0.d_valid), 128'd0);
      chk("rput_ack_zero", 128'(ack0), 128'd0);
    end
    @(posedge clk);
    #1;
    issue0(3'd4, 3'd3, 4'd2, B + 64'h10, 8'hFF, 64'd0, 3'd1, 1'b0, 64'h11223344_BBBBBBBB);
    chk("ack_after_rst", 128'(ack0), 128'd1);
    b1.a_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      b1.a_opcode = v_op[k];
      b1.a_size = 3'd3;
      b1.a_source = 4'(k + 1);
      b1.a_address = v_addr[k];
      b1.a_mask = v_mask[k];
      b1.a_data = v_data[k];
      n = 0;
      @(negedge clk);
      while (!b1.a_ready && n < 20) begin
        n++;
        @(negedge clk);
      end
      chk("b1_accept", 128'(b1.a_ready), 128'd1);
      if (k > 0) chk("b1_gap", 128'(cyc - prev), 128'd2);
      prev = cyc;
      q1.push_back({e_op[k], 2'b01, 3'd3, 4'(k + 1), e_err[k], e_data[k]});
      @(posedge clk);
      #1 if (k == 4) b1.a_valid = 1'b0;
      @(negedge clk);
      chk("b1_latency1", 128'(b1.d_valid), 128'd1);
    end
    @(posedge clk);
    #1;
    chk("b1_ack_cnt", 128'(ack1), 128'd5);
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("queues_drained", 128'(q0.size() + q1.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
